// File: rtl/bcd_scan_decoder.sv
// ---------------------------------------------------------------------------
// bcd_scan_decoder
// Captures a frame of packed BCD digits and presents the digits one at a time,
// each held for SCAN_DIV cycles, as a one-hot decimal decode with a matching
// one-hot digit select. Invalid codes (10..15) are flagged per digit and
// remembered across the frame. Optional continuous mode rescans a freshly
// captured frame without a new load.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   load      start request (honoured only in IDLE and not during done)
//   cont      continuous mode: recapture bcd_in and rescan at frame end
//   bcd_in    packed BCD frame, digit 0 in bits [3:0], scanned first
//   dec_out   one-hot decode of the presented digit (0 for invalid / idle)
//   dig_sel   one-hot select of the presented digit, 0 when idle
//   err       presented digit code is 10..15
//   err_seen  sticky invalid flag for the current or last frame
//   busy      scanning
//   done      one-cycle pulse at each frame completion
// ---------------------------------------------------------------------------
module bcd_scan_decoder #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  cont,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [9:0]            dec_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  err,
    output logic                  err_seen,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned FRAME_W = 4 * DIGITS;
    // A single-digit frame still gets a 1-bit index so the select logic stays uniform.
    localparam int unsigned DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DIV_W   = $clog2(SCAN_DIV);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [DIV_W-1:0]     div_q,   div_d;
    logic [DIG_W-1:0]     dig_q,   dig_d;
    logic [9:0]           dec_q,   dec_d;
    logic [DIGITS-1:0]    sel_q,   sel_d;
    logic                 err_q,   err_d;
    logic                 seen_q,  seen_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    // Presentation path for the digit shown after the next edge.
    logic                 show;
    logic                 clr_seen;
    logic [FRAME_W-1:0]   src;
    logic [DIG_W-1:0]     idx;
    logic [3:0]           code;
    logic                 invalid;

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        div_d    = div_q;
        dig_d    = dig_q;
        done_d   = 1'b0;
        show     = 1'b0;
        clr_seen = 1'b0;
        src      = frame_q;
        idx      = dig_q;
        code     = 4'd0;
        dec_d    = '0;
        sel_d    = '0;

        case (state_q)
            IDLE: begin
                // A load coinciding with the done cycle is dropped.
                if (load && !done_q) begin
                    state_d  = SCAN;
                    frame_d  = bcd_in;
                    div_d    = '0;
                    dig_d    = '0;
                    src      = bcd_in;
                    idx      = '0;
                    show     = 1'b1;
                    clr_seen = 1'b1;
                end
            end
            SCAN: begin
                show = 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (dig_q == DIG_LAST) begin
                        done_d = 1'b1;
                        dig_d  = '0;
                        idx    = '0;
                        if (cont) begin
                            // Wrap: present digit 0 of the newly captured frame.
                            frame_d  = bcd_in;
                            src      = bcd_in;
                            clr_seen = 1'b1;
                        end else begin
                            state_d = IDLE;
                            show    = 1'b0;
                        end
                    end else begin
                        dig_d = dig_q + 1'b1;
                        idx   = dig_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase

        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == DIG_W'(i)) begin
                code = src[4*i +: 4];
            end
            sel_d[i] = show && (idx == DIG_W'(i));
        end

        invalid = (code > 4'd9);
        for (int n = 0; n < 10; n++) begin
            dec_d[n] = show && (code == 4'(n));
        end

        err_d  = show && invalid;
        seen_d = (seen_q && !clr_seen) || (show && invalid);
        busy_d = (state_d == SCAN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            div_q   <= '0;
            dig_q   <= '0;
            dec_q   <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            div_q   <= div_d;
            dig_q   <= dig_d;
            dec_q   <= dec_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dec_out  = dec_q;
    assign dig_sel  = sel_q;
    assign err      = err_q;
    assign err_seen = seen_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_decoder
// Directed bench for bcd_scan_decoder: a 4-digit / 4-cycle instance and a
// 1-digit / 2-cycle instance sharing clock and reset. Inputs are driven and
// outputs sampled 1 time unit after each rising edge. The edge that samples
// load high is called E0; outputs after E0 show digit 0 and the done pulse
// appears after E(DIGITS*SCAN_DIV).
// ---------------------------------------------------------------------------
module tb_bcd_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load, cont;
    logic [15:0] bcd_in;
    logic [9:0]  dec_out;
    logic [3:0]  dig_sel;
    logic        err, err_seen, busy, done;

    logic        load1, cont1;
    logic [3:0]  bcd1;
    logic [9:0]  dec1;
    logic [0:0]  sel1;
    logic        err1, seen1, busy1, done1;

    int ncmp = 0;
    int nerr = 0;

    // Hand-decoded digit values, digit 0 first.
    logic [9:0] exp_1937 [4] = '{10'h080, 10'h008, 10'h200, 10'h002};
    logic [9:0] exp_0a50 [4] = '{10'h001, 10'h020, 10'h000, 10'h001};

    bcd_scan_decoder #(.DIGITS(4), .SCAN_DIV(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .cont     (cont),
        .bcd_in   (bcd_in),
        .dec_out  (dec_out),
        .dig_sel  (dig_sel),
        .err      (err),
        .err_seen (err_seen),
        .busy     (busy),
        .done     (done)
    );

    bcd_scan_decoder #(.DIGITS(1), .SCAN_DIV(2)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load1),
        .cont     (cont1),
        .bcd_in   (bcd1),
        .dec_out  (dec1),
        .dig_sel  (sel1),
        .err      (err1),
        .err_seen (seen1),
        .busy     (busy1),
        .done     (done1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_dec"},  32'(dec_out),  32'h0);
        chk({tag, "_sel"},  32'(dig_sel),  32'h0);
        chk({tag, "_err"},  32'(err),      32'h0);
        chk({tag, "_seen"}, 32'(err_seen), 32'h0);
        chk({tag, "_busy"}, 32'(busy),     32'h0);
        chk({tag, "_done"}, 32'(done),     32'h0);
    endtask

    initial begin
        rst_n  = 1'b1;
        load   = 1'b0;
        cont   = 1'b0;
        bcd_in = 16'h0;
        load1  = 1'b0;
        cont1  = 1'b0;
        bcd1   = 4'h0;

        // Reset state
        #2 rst_n = 1'b0;
        step();
        step();
        chk_idle("rst");
        chk("rst_busy1", 32'(busy1), 32'h0);
        chk("rst_sel1",  32'(sel1),  32'h0);

        // Release between edges; load honoured on the very next edge.
        rst_n  = 1'b1;
        load   = 1'b1;
        bcd_in = 16'h1937;
        for (int k = 0; k < 16; k++) begin
            step();
            if (k == 0) load = 1'b0;
            chk("t1_sel",  32'(dig_sel), 32'(4'(1) << (k / 4)));
            chk("t1_dec",  32'(dec_out), 32'(exp_1937[k / 4]));
            chk("t1_busy", 32'(busy),    32'h1);
            chk("t1_done", 32'(done),    32'h0);
        end
        step();
        chk("t1_done_end", 32'(done),    32'h1);
        chk("t1_busy_end", 32'(busy),    32'h0);
        chk("t1_sel_end",  32'(dig_sel), 32'h0);
        chk("t1_dec_end",  32'(dec_out), 32'h0);
        // Load in the done cycle is ignored.
        load = 1'b1;
        step();
        load = 1'b0;
        chk("t1_ld_done_busy", 32'(busy), 32'h0);
        chk("t1_done_clr",     32'(done), 32'h0);
        step();
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // Invalid digit, plus stray loads at cycles 5 and 16.
        load   = 1'b1;
        bcd_in = 16'h0A50;
        for (int k = 0; k < 16; k++) begin
            step();
            if (k == 0)  load = 1'b0;
            if (k == 4)  load = 1'b1;
            if (k == 5)  load = 1'b0;
            if (k == 15) load = 1'b1;
            chk("t2_sel",  32'(dig_sel),  32'(4'(1) << (k / 4)));
            chk("t2_dec",  32'(dec_out),  32'(exp_0a50[k / 4]));
            chk("t2_err",  32'(err),      32'((k / 4) == 2));
            chk("t2_seen", 32'(err_seen), 32'(k >= 8));
            chk("t2_done", 32'(done),     32'h0);
        end
        step();
        load = 1'b0;
        chk("t2_done_end", 32'(done),     32'h1);
        chk("t2_busy_end", 32'(busy),     32'h0);
        chk("t2_err_end",  32'(err),      32'h0);
        chk("t2_seen_end", 32'(err_seen), 32'h1);
        step();
        step();
        chk("t2_no_restart", 32'(busy),     32'h0);
        chk("t2_seen_hold",  32'(err_seen), 32'h1);

        // Continuous mode: recapture at wrap, then cont dropped mid-frame.
        cont   = 1'b1;
        load   = 1'b1;
        bcd_in = 16'h2222;
        for (int k = 0; k <= 32; k++) begin
            step();
            if (k == 0)  load = 1'b0;
            if (k == 8)  bcd_in = 16'h4444;
            if (k == 20) cont = 1'b0;
            chk("t3_dec",  32'(dec_out),
                (k < 16) ? 32'h004 : ((k < 32) ? 32'h010 : 32'h0));
            chk("t3_sel",  32'(dig_sel),
                (k == 32) ? 32'h0 : 32'(4'(1) << ((k % 16) / 4)));
            chk("t3_done", 32'(done), 32'((k == 16) || (k == 32)));
            chk("t3_busy", 32'(busy), 32'(k < 32));
            chk("t3_seen", 32'(err_seen), 32'h0);
        end
        step();
        chk("t3_done_clr", 32'(done), 32'h0);

        // Reset mid-frame between edges: immediate clear, no done.
        load   = 1'b1;
        bcd_in = 16'h1937;
        for (int k = 0; k <= 8; k++) begin
            step();
            if (k == 0) load = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk_idle("t4_async");
        step();
        chk("t4_rst_done", 32'(done), 32'h0);
        step();
        chk("t4_rst_busy", 32'(busy), 32'h0);
        rst_n  = 1'b1;
        load   = 1'b1;
        bcd_in = 16'h5555;
        step();
        load = 1'b0;
        chk("t4_new_sel",  32'(dig_sel),  32'h1);
        chk("t4_new_dec",  32'(dec_out),  32'h020);
        chk("t4_new_seen", 32'(err_seen), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("t4_done", 32'(done), 32'(k == 16));
        end

        // Single digit, two cycles per digit.
        load1 = 1'b1;
        bcd1  = 4'h0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (k == 0) load1 = 1'b0;
            chk("t5_dec",  32'(dec1),  32'h001);
            chk("t5_sel",  32'(sel1),  32'h1);
            chk("t5_done", 32'(done1), 32'h0);
        end
        step();
        chk("t5_done_end", 32'(done1), 32'h1);
        chk("t5_busy_end", 32'(busy1), 32'h0);
        chk("t5_sel_end",  32'(sel1),  32'h0);
        step();

        // Single digit continuous wrap.
        cont1 = 1'b1;
        load1 = 1'b1;
        bcd1  = 4'h3;
        for (int k = 0; k <= 4; k++) begin
            step();
            if (k == 0) load1 = 1'b0;
            if (k == 2) cont1 = 1'b0;
            chk("t6_dec",  32'(dec1),  (k < 4) ? 32'h008 : 32'h0);
            chk("t6_sel",  32'(sel1),  32'(k < 4));
            chk("t6_done", 32'(done1), 32'((k == 2) || (k == 4)));
            chk("t6_busy", 32'(busy1), 32'(k < 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
